// File: rtl/parity_pkg.sv
// Shared types for the serial running-parity block.
package parity_pkg;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } parity_state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity.sv
// Serial running-parity generator/checker, one input bit per clock.
module parity
    import parity_pkg::*;
#(
    parameter bit ODD_PARITY = PAR_EVEN
) (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic par
);

    parity_state_t state_q;
    parity_state_t state_d;
    logic          par_q;
    logic          par_d;

    always_comb begin
        state_d = state_q;
        if (inp) begin
            state_d = (state_q == S_ODD) ? S_EVEN : S_ODD;
        end
        par_d = (state_d == S_ODD) ^ ODD_PARITY;
    end

    // par is kept in its own flop so it never sees a path from inp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EVEN;
            par_q   <= ODD_PARITY;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
        end
    end

    assign par = par_q;

endmodule

// File: tb/tb_parity.sv
// Directed scoreboard bench for parity, even and odd flavours side by side.
module tb_parity;

    typedef struct {
        string tag;
        logic  e0;
        logic  e1;
    } exp_t;

    logic clk;
    logic rst;
    logic inp;
    logic par0;
    logic par1;

    int   checks;
    int   errors;
    bit   model;
    exp_t sb[$];

    parity #(.ODD_PARITY(1'b0)) u_even (
        .clk(clk),
        .rst(rst),
        .inp(inp),
        .par(par0)
    );

    parity #(.ODD_PARITY(1'b1)) u_odd (
        .clk(clk),
        .rst(rst),
        .inp(inp),
        .par(par1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one bit at the falling edge, check just after the rising edge.
    task automatic step(input logic b, input string tag);
        exp_t e;
        @(negedge clk);
        inp = b;
        model = model ^ b;
        e.tag = tag;
        e.e0  = model;
        e.e1  = ~model;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, "_even"}, par0, e.e0);
        chk({e.tag, "_odd"}, par1, e.e1);
    endtask

    // Short reset pulse placed between edges; par must clear at once.
    task automatic pulse_rst(input string tag);
        @(negedge clk);
        inp = 1'b0;
        #1;
        rst = 1'b0;
        model = 1'b0;
        #1;
        chk({tag, "_even"}, par0, 1'b0);
        chk({tag, "_odd"}, par1, 1'b1);
        #2;
        rst = 1'b1;
    endtask

    task automatic frame(input logic [7:0] f, input string tag);
        for (int i = 7; i >= 0; i--) begin
            step(f[i], $sformatf("%s_b%0d", tag, i));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = 1'b0;
        inp    = 1'b0;
        rst    = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        chk("rst_async_even", par0, 1'b0);
        chk("rst_async_odd", par1, 1'b1);
        #3;
        chk("rst_hold_even", par0, 1'b0);
        chk("rst_hold_odd", par1, 1'b1);
        #2;
        rst = 1'b1;

        frame(8'h84, "f84");
        chk("f84_final_even", par0, 1'b0);
        chk("f84_final_odd", par1, 1'b1);

        pulse_rst("rst_ff");
        frame(8'hFF, "fFF");
        chk("fFF_final_even", par0, 1'b0);

        pulse_rst("rst_01");
        frame(8'h01, "f01");
        chk("f01_final_even", par0, 1'b1);
        chk("f01_final_odd", par1, 1'b0);

        pulse_rst("rst_mid0");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $sformatf("mid_b%0d", i));
        end
        chk("mid_par1", par0, 1'b1);
        pulse_rst("rst_mid");
        step(1'b1, "after_rst");
        chk("after_rst_par1", par0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step(1'b0, $sformatf("hold0_%0d", i));
        end
        chk("hold0_final", par0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            step(1'($urandom_range(0, 1)), $sformatf("rnd_%0d", i));
        end

        chk("sb_empty", 1'(sb.size() == 0), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
